// File: rtl/rotation_parser_if.sv
// -----------------------------------------------------------------------------
// rotation_parser_if
//
// Handshake bundle between a byte source, the rotation_parser and the
// dial-rotation core. It carries two streams:
//   byte stream    : in_valid, in_data[7:0], in_last  (source -> parser)
//                    in_ready                         (parser -> source)
//   command stream : cmd_valid, cmd_direction,
//                    cmd_distance[DIST_W-1:0]         (parser -> core)
//                    cmd_ready                        (core -> parser)
//
// Modports:
//   slave  : the parser side (consumes bytes, produces commands)
//   master : the environment side (byte source plus command sink)
// -----------------------------------------------------------------------------
interface rotation_parser_if #(
  parameter int DIST_W = 16
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;

  logic              cmd_valid;
  logic              cmd_direction;
  logic [DIST_W-1:0] cmd_distance;
  logic              cmd_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output cmd_valid,
    output cmd_direction,
    output cmd_distance,
    input  cmd_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  cmd_valid,
    input  cmd_direction,
    input  cmd_distance,
    output cmd_ready
  );

endinterface

// File: rtl/rotation_parser.sv
// -----------------------------------------------------------------------------
// rotation_parser
//
// Byte-stream front end for the dial-rotation core. Raw ASCII lines such as
// "R48\n" or "L5\n" are decoded into {direction, distance} commands that are
// handed to the core over a valid/ready handshake.
//
// Parameters:
//   DIST_W      width of the decoded distance (matches the core's port)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   bus         rotation_parser_if.slave
//                 in_valid/in_data/in_last/in_ready : byte input stream
//                 cmd_valid/cmd_direction/cmd_distance/cmd_ready : commands
//   line_count  commands handed off, saturating at 16'hFFFF
//   err_count   rejected or saturated lines, saturating at 16'hFFFF
//   done        sticky; stream consumed and final command handed off
//
// Build option:
//   ROTATION_PARSER_CRLF_EN  when defined, carriage return (0x0D) is ignored
//                            while reading or skipping a line, so CRLF text
//                            decodes like LF text. When undefined it is an
//                            ordinary invalid byte.
// -----------------------------------------------------------------------------
module rotation_parser #(
  parameter int DIST_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rotation_parser_if.slave bus,
  output logic [15:0]      line_count,
  output logic [15:0]      err_count,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    DIGITS,
    EMIT,
    SKIP,
    FIN
  } state_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  state_t            state;
  logic              live;
  logic              dir_q;
  logic [DIST_W-1:0] acc;
  logic              digit_seen;
  logic              sat_seen;
  logic              fin_pending;

  logic              cmd_valid_q;
  logic              cmd_dir_q;
  logic [DIST_W-1:0] cmd_dist_q;

  logic              accept;
  logic              is_lf;
  logic              is_cr;
  logic              is_dir;
  logic              is_digit;
  logic              to_emit;
  logic [3:0]        digit_val;
  logic [DIST_W+3:0] acc_wide;
  logic              acc_ovf;
  logic [DIST_W-1:0] acc_upd;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 'live' holds in_ready low while reset is asserted and for no longer:
  // it rises on the first clock edge after release.
  assign bus.in_ready = live && ((state == IDLE) || (state == DIGITS) || (state == SKIP));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_direction = cmd_dir_q;
  assign bus.cmd_distance  = cmd_dist_q;

  assign is_lf    = (bus.in_data == CH_LF);
  assign is_dir   = (bus.in_data == CH_R) || (bus.in_data == CH_L);
  assign is_digit = (bus.in_data >= CH_0) && (bus.in_data <= CH_9);

`ifdef ROTATION_PARSER_CRLF_EN
  localparam logic [7:0] CH_CR = 8'h0D;
  assign is_cr = (bus.in_data == CH_CR);
`else
  assign is_cr = 1'b0;
`endif

  // acc*10 + digit computed four bits wider than the accumulator so that any
  // carry out of the top means the true value no longer fits. Once saturated
  // the accumulator is all-ones, which overflows again on every further digit
  // and therefore stays pinned.
  assign digit_val = bus.in_data[3:0];
  assign acc_wide  = ({4'd0, acc} << 3) + ({4'd0, acc} << 1)
                   + {{DIST_W{1'b0}}, digit_val};
  assign acc_ovf   = |acc_wide[DIST_W+3:DIST_W];
  assign acc_upd   = acc_ovf ? {DIST_W{1'b1}} : acc_wide[DIST_W-1:0];

  // A line is complete either on its newline (once at least one digit has been
  // seen) or on a digit that is also the final byte of the stream.
  assign to_emit = (state == DIGITS) &&
                   ((is_lf && digit_seen) || (is_digit && bus.in_last));

  // Line decoder. The byte is first processed as usual; a final byte that does
  // not complete a command then overrides the destination with FIN. A final
  // byte that does complete one goes to EMIT and remembers to finish after the
  // handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      live        <= 1'b0;
      dir_q       <= 1'b0;
      acc         <= '0;
      digit_seen  <= 1'b0;
      sat_seen    <= 1'b0;
      fin_pending <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 1'b0;
      cmd_dist_q  <= '0;
      line_count  <= '0;
      err_count   <= '0;
      done        <= 1'b0;
    end else begin
      live <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_dir) begin
              dir_q      <= (bus.in_data == CH_R);
              acc        <= '0;
              digit_seen <= 1'b0;
              sat_seen   <= 1'b0;
              state      <= DIGITS;
            end else if (!(is_lf || is_cr)) begin
              err_count <= sat_inc(err_count);
              state     <= SKIP;
            end
          end
        end

        DIGITS: begin
          if (accept) begin
            if (is_digit) begin
              acc        <= acc_upd;
              sat_seen   <= sat_seen | acc_ovf;
              digit_seen <= 1'b1;
            end else if (is_lf && digit_seen) begin
              state <= DIGITS;
            end else if (is_cr) begin
              // A stream that ends on a carriage return leaves the line unfinished.
              if (bus.in_last) begin
                err_count <= sat_inc(err_count);
              end
            end else begin
              err_count <= sat_inc(err_count);
              state     <= is_lf ? IDLE : SKIP;
            end

            if (to_emit) begin
              cmd_valid_q <= 1'b1;
              cmd_dir_q   <= dir_q;
              cmd_dist_q  <= is_digit ? acc_upd : acc;
              fin_pending <= bus.in_last;
              state       <= EMIT;
            end
          end
        end

        EMIT: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            line_count  <= sat_inc(line_count);
            if (sat_seen) begin
              err_count <= sat_inc(err_count);
            end
            if (fin_pending) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        SKIP: begin
          if (accept && is_lf) begin
            state <= IDLE;
          end
        end

        FIN: begin
          state <= FIN;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (accept && bus.in_last && !to_emit) begin
        state <= FIN;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rotation_parser.sv
// -----------------------------------------------------------------------------
// tb_rotation_parser
//
// Self-checking bench for rotation_parser: a table of whole-stream vectors
// with hand-derived results, hand-written sequences for latency, backpressure
// and reset, and randomized streams checked against a line-level model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rotation_parser;

`ifdef ROTATION_PARSER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] line_count;
  logic [15:0] err_count;
  logic        done;

  rotation_parser_if #(.DIST_W(16)) bus ();

  rotation_parser #(.DIST_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .line_count(line_count),
    .err_count (err_count),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string stream;
    bit    lastFlag;
    string cmds;
    int    lines;
    int    errs;
    bit    fin;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  bit           randomReady = 1'b0;
  int           gotDir[$];
  int           gotDist[$];
  int           expDir[$];
  int           expDist[$];
  int           expErr;
  int           expLines;
  byte unsigned stim[$];
  vec_t         vecs[$];

  // Comparison helpers -------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
    end
  endtask

  task automatic checkText(input string name, input string actual, input string expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got \"%s\", wanted \"%s\"", name, actual, expected);
    end
  endtask

  // Command sink: records handshakes and checks that a stalled command holds.
  initial begin : monitor
    logic        prevHold;
    logic        prevDir;
    logic [15:0] prevDist;
    prevHold = 1'b0;
    prevDir  = 1'b0;
    prevDist = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevHold = 1'b0;
      end else begin
        if (prevHold) begin
          checkOutput("hold_valid", 32'(bus.cmd_valid), 32'd1);
          checkOutput("hold_fields", {15'd0, bus.cmd_direction, bus.cmd_distance},
                      {15'd0, prevDir, prevDist});
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          gotDir.push_back(int'(bus.cmd_direction));
          gotDist.push_back(int'(bus.cmd_distance));
        end
        prevHold = bus.cmd_valid && !bus.cmd_ready;
        prevDir  = bus.cmd_direction;
        prevDist = bus.cmd_distance;
      end
    end
  end

  initial begin : readyDriver
    forever begin
      @(posedge clk);
      #1;
      if (randomReady) bus.cmd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500us, wanted finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus helpers ---------------------------------------------------------
  task automatic sendByte(input logic [7:0] b, input bit last);
    int waited;
    bit ok;
    waited = 0;
    ok     = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_accept: in_ready stayed 0 for byte %02h, wanted 1", b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input bit lastFlag, input int gapMax);
    for (int i = 0; i < stim.size(); i++) begin
      sendByte(stim[i], lastFlag && (i == stim.size() - 1));
      if (gapMax > 0) repeat ($urandom_range(0, gapMax)) @(posedge clk);
    end
  endtask

  task automatic loadText(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 400 && bus.cmd_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.cmd_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: cmd_valid still 1 after 400 cycles, wanted 0");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gotDir.delete();
    gotDist.delete();
  endtask

  function automatic string cmdText();
    string t;
    t = "";
    foreach (gotDir[i]) t = {t, $sformatf("%s%0d ", (gotDir[i] != 0) ? "R" : "L", gotDist[i])};
    return t;
  endfunction

  function automatic void addVec(input string s, input bit l, input string c,
                                 input int ln, input int er, input bit f);
    vec_t v;
    v.stream   = s;
    v.lastFlag = l;
    v.cmds     = c;
    v.lines    = ln;
    v.errs     = er;
    v.fin      = f;
    vecs.push_back(v);
  endfunction

  // Reference model: splits the stream into lines and judges each line whole.
  function automatic void modelLine(input byte unsigned raw[$]);
    byte unsigned t[$];
    longint       v;
    bit           bad;
    v   = 0;
    bad = 1'b0;
    foreach (raw[i]) if (!(CRLF && raw[i] == 8'h0D)) t.push_back(raw[i]);
    if (t.size() == 0) return;
    if (!(t[0] == 8'h52 || t[0] == 8'h4C) || t.size() == 1) begin
      expErr++;
      return;
    end
    for (int i = 1; i < t.size(); i++) begin
      if (t[i] < 8'h30 || t[i] > 8'h39) bad = 1'b1;
      else begin
        v = v * 10 + longint'(t[i] - 8'h30);
        if (v > 65535) v = 65536;
      end
    end
    if (bad) begin
      expErr++;
      return;
    end
    expDir.push_back((t[0] == 8'h52) ? 1 : 0);
    expDist.push_back((v > 65535) ? 65535 : int'(v));
    expLines++;
    if (v > 65535) expErr++;
  endfunction

  task automatic modelStream();
    byte unsigned line[$];
    expDir.delete();
    expDist.delete();
    expErr   = 0;
    expLines = 0;
    foreach (stim[i]) begin
      if (stim[i] == 8'h0A) begin
        modelLine(line);
        line.delete();
      end else begin
        line.push_back(stim[i]);
      end
    end
    if (line.size() > 0) modelLine(line);
  endtask

  task automatic pushDigits(input int n);
    for (int k = 0; k < n; k++) stim.push_back(byte'(8'h30 + $urandom_range(0, 9)));
  endtask

  task automatic pushDir();
    stim.push_back(($urandom_range(0, 1) != 0) ? 8'h52 : 8'h4C);
  endtask

  task automatic genStream(output bit lastFlag);
    int nLines;
    int kind;
    bit noLf;
    stim.delete();
    nLines   = $urandom_range(6, 16);
    lastFlag = ($urandom_range(0, 1) != 0);
    for (int l = 0; l < nLines; l++) begin
      kind = $urandom_range(0, 7);
      noLf = (l == nLines - 1) && lastFlag && ($urandom_range(0, 1) != 0);
      if (noLf) kind = 0;
      case (kind)
        0, 1, 2: begin pushDir(); pushDigits($urandom_range(1, 6)); end
        3: ;
        4: begin stim.push_back(byte'(8'h41 + $urandom_range(0, 5))); pushDigits(2); end
        5: pushDir();
        6: begin pushDir(); pushDigits(1); stim.push_back(8'h7A); pushDigits(1); end
        default: begin pushDir(); pushDigits($urandom_range(1, 3)); stim.push_back(8'h0D); end
      endcase
      if (!noLf) stim.push_back(8'h0A);
    end
  endtask

  // Main sequence ------------------------------------------------------------
  initial begin : main
    bit lastFlag;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.cmd_ready = 1'b0;

    // Values while reset is held.
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    checkOutput("rst_cmd_fields", {15'd0, bus.cmd_direction, bus.cmd_distance}, 32'd0);
    checkOutput("rst_line_count", 32'(line_count), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: command visible right after the newline edge, gone one edge later.
    bus.cmd_ready = 1'b1;
    loadText("R48\n");
    applyStimulus(1'b0, 0);
    checkOutput("lat_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    checkOutput("lat_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("lat_dir", 32'(bus.cmd_direction), 32'd1);
    checkOutput("lat_dist", 32'(bus.cmd_distance), 32'd48);
    @(posedge clk);
    #1;
    checkOutput("lat_valid_clear", 32'(bus.cmd_valid), 32'd0);
    checkOutput("lat_ready_again", 32'(bus.in_ready), 32'd1);
    checkOutput("lat_line_count", 32'(line_count), 32'd1);

    // Table of whole streams with hand-derived results.
    addVec("R48\nL5\n", 1'b0, "R48 L5 ", 2, 0, 1'b0);
    addVec("X12\nR\nL7a\n\nR65536\n", 1'b0, "R65535 ", 1, 4, 1'b0);
    addVec("L99", 1'b1, "L99 ", 1, 0, 1'b1);
    if (CRLF) addVec("R12\r\n", 1'b0, "R12 ", 1, 0, 1'b0);
    else      addVec("R12\r\n", 1'b0, "", 0, 1, 1'b0);
    addVec("R0\nL65535\nR999999\n", 1'b0, "R0 L65535 R65535 ", 3, 1, 1'b0);
    addVec("\n\nL1\n", 1'b1, "L1 ", 1, 0, 1'b1);
    addVec("R7\nQ", 1'b1, "R7 ", 1, 1, 1'b1);
    addVec("L12R\n", 1'b0, "", 0, 1, 1'b0);
    addVec("R\n", 1'b1, "", 0, 1, 1'b1);
    addVec("L3x", 1'b1, "", 0, 1, 1'b1);
    addVec("R12\r", 1'b1, "", 0, 1, 1'b1);

    for (int v = 0; v < vecs.size(); v++) begin
      applyReset();
      bus.cmd_ready = 1'b1;
      loadText(vecs[v].stream);
      applyStimulus(vecs[v].lastFlag, 0);
      drain();
      checkText($sformatf("vec%0d_cmds", v), cmdText(), vecs[v].cmds);
      checkOutput($sformatf("vec%0d_lines", v), 32'(line_count), 32'(vecs[v].lines));
      checkOutput($sformatf("vec%0d_errs", v), 32'(err_count), 32'(vecs[v].errs));
      checkOutput($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].fin));
      if (vecs[v].fin) checkOutput($sformatf("vec%0d_in_ready", v), 32'(bus.in_ready), 32'd0);
    end

    // Backpressure: a stalled command holds for 10 cycles, then hands off once.
    applyReset();
    bus.cmd_ready = 1'b0;
    loadText("L5\n");
    applyStimulus(1'b0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("bp_cmd_valid", 32'(bus.cmd_valid), 32'd1);
      checkOutput("bp_fields", {15'd0, bus.cmd_direction, bus.cmd_distance}, 32'd5);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b1;
    drain();
    checkOutput("bp_handshakes", 32'(gotDir.size()), 32'd1);
    checkOutput("bp_line_count", 32'(line_count), 32'd1);

    // Reset in the middle of a line discards it and clears the counters.
    applyReset();
    bus.cmd_ready = 1'b1;
    loadText("Q\nR12");
    applyStimulus(1'b0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    checkOutput("midrst_err_count", 32'(err_count), 32'd0);
    checkOutput("midrst_line_count", 32'(line_count), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gotDir.delete();
    gotDist.delete();
    loadText("L3\n");
    applyStimulus(1'b0, 0);
    drain();
    checkText("midrst_after", cmdText(), "L3 ");

    // Reset while a command is pending drops it without a handshake.
    applyReset();
    bus.cmd_ready = 1'b0;
    loadText("R9\n");
    applyStimulus(1'b0, 0);
    checkOutput("emitrst_pending", 32'(bus.cmd_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("emitrst_valid", 32'(bus.cmd_valid), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.cmd_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("emitrst_handshakes", 32'(gotDir.size()), 32'd0);
    checkOutput("emitrst_line_count", 32'(line_count), 32'd0);

    // Randomized streams against the line model.
    for (int r = 0; r < 8; r++) begin
      applyReset();
      genStream(lastFlag);
      modelStream();
      randomReady = 1'b1;
      applyStimulus(lastFlag, 2);
      drain();
      randomReady = 1'b0;
      checkOutput($sformatf("rnd%0d_cmd_count", r), 32'(gotDir.size()), 32'(expDir.size()));
      for (int i = 0; i < expDir.size() && i < gotDir.size(); i++) begin
        checkOutput($sformatf("rnd%0d_dir%0d", r, i), 32'(gotDir[i]), 32'(expDir[i]));
        checkOutput($sformatf("rnd%0d_dist%0d", r, i), 32'(gotDist[i]), 32'(expDist[i]));
      end
      checkOutput($sformatf("rnd%0d_lines", r), 32'(line_count), 32'(expLines));
      checkOutput($sformatf("rnd%0d_errs", r), 32'(err_count), 32'(expErr));
      checkOutput($sformatf("rnd%0d_done", r), 32'(done), 32'(lastFlag));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotation_parser.md
# rotation_parser

Byte-stream front end for the dial-rotation core (`sequential`). It accepts the puzzle input as raw ASCII bytes (`R48\n`, `L5\n`, …) and decodes each line into one `{direction, distance}` command. Commands go out on a valid/ready handshake that drives the core's `valid`/`direction`/`distance`/`ready` ports. This replaces host-side text parsing, so a UART or ROM byte source can feed the core directly in hardware.

## Interface
Parameters:
- `DIST_W`, default 16: width of the decoded distance; must match the core's `distance` port.

Ports:
- `clk`  in  1: single clock domain, all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_data` holds a byte.
- `in_data`  in  8: ASCII byte.
- `in_last`  in  1: qualifies the final byte of the stream.
- `in_ready`  out  1: parser accepts the byte this cycle.
- `cmd_valid`  out  1: command available.
- `cmd_direction`  out  1: 1 = `R`, 0 = `L`.
- `cmd_distance`  out  DIST_W: decoded decimal distance.
- `cmd_ready`  in  1: core accepts the command.
- `line_count`  out  16: commands emitted, saturating at 16'hFFFF.
- `err_count`  out  16: lines rejected or saturated, saturating at 16'hFFFF.
- `done`  out  1: sticky; stream fully consumed and the last command handed off.

## Operation
- A byte is accepted when `in_valid && in_ready`. The cmd handshake completes when `cmd_valid && cmd_ready`.
- States are `IDLE`, `DIGITS`, `EMIT`, `SKIP`, `FIN`.
- **IDLE**, waiting for the start of a line:
  - `R` or `L`: latch direction, clear the accumulator and digit flag, go to `DIGITS`.
  - `\n`: blank line, ignored, no count.
  - Any other byte: `err_count`++, go to `SKIP`.
- **DIGITS**:
  - `0`–`9`: `acc = acc*10 + digit`, set the digit flag. If the true result exceeds 2^DIST_W−1, `acc` saturates at all-ones and the sat flag is set.
  - `\n` with the digit flag set: go to `EMIT`.
  - `\n` with no digits (e.g. `R\n`): `err_count`++, go to `IDLE`.
  - Any other byte: `err_count`++, go to `SKIP`.
- **EMIT**:
  - `cmd_valid`=1; `cmd_direction`/`cmd_distance` are registered and held stable.
  - `in_ready`=0.
  - On handshake: `line_count`++, plus `err_count`++ if the sat flag is set. Go to `IDLE`, or to `FIN` if this line ended on `in_last`.
- **SKIP**: discard bytes up to and including `\n`, then go to `IDLE`.
- **`in_last` handling**: the byte is processed normally first.
  - If the result is `EMIT`, or the byte is a digit that completes a valid line, go to `EMIT` with a FIN-pending flag set.
  - `in_last` on a non-digit in `DIGITS` counts as a line error.
  - Otherwise go to `FIN`.
- **FIN**: `done`=1, `in_ready`=0. Leave only via reset.
- `in_ready` = 1 in `IDLE`, `DIGITS` and `SKIP`; 0 in `EMIT` and `FIN`.

## Timing
- Reset values: `in_ready`=0 during reset, 1 from the first cycle after release. `cmd_valid`=0, `cmd_direction`=0, `cmd_distance`=0, `line_count`=0, `err_count`=0, `done`=0. State is `IDLE` with all flags clear.
- Latency: the terminating `\n` (or `in_last` digit) is accepted at edge N; `cmd_valid` is high after edge N. If `cmd_ready`=1, the handshake completes at edge N+1 and `in_ready` is high again after N+1.
- Throughput is one byte per cycle inside a line, plus at least 1 stall cycle per command.
- `cmd_valid` never drops without a handshake. Command fields never change while `cmd_valid`=1.
- Counter saturation: increments at 16'hFFFF are dropped.
- Reset mid-line or during `EMIT`: the partial line and the pending command are discarded. No handshake or count is generated.
- A simultaneous `in_valid` during `EMIT` is not accepted; the source must hold the byte.

## Configuration
- `ROTATION_PARSER_CRLF_EN` defined: byte `\r` (0x0D) is ignored as a no-op in `IDLE`, `DIGITS` and `SKIP`, so `R12\r\n` yields R/12.
- Undefined: `\r` is an ordinary invalid byte. `R12\r\n` takes `err_count`++ and `SKIP`, and no command is emitted.

## Test plan
- Stream `R48\nL5\n` with `cmd_ready`=1 -> commands (1,48) then (0,5). `line_count`=2, `err_count`=0. First `cmd_valid` appears 1 cycle after the first `\n` is accepted.
- `cmd_ready` held low 10 cycles during `EMIT` -> `cmd_valid` stays 1 with fields stable and `in_ready`=0. After release: exactly one handshake.
- `X12\nR\nL7a\n\nR65536\n` -> only (1,65535) emitted. `err_count`=4, `line_count`=1.
- Final bytes `L99` with `in_last` on `9` and no newline -> command (0,99) emitted, then `done`=1 and `in_ready`=0.
- Assert `rst_n`=0 after `R12` is accepted -> no command is emitted and both counters read 0. Then `L3\n` -> (0,3).
- `R12\r\n` -> (1,12) with the macro defined. Without it: no command and `err_count`=1.
